// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: parametrised register file with one-hot write decode and pending-write scoreboard
// Ports:
//   clock, ctrl_reset (sync, active-low)
//   ctrl_writeEnable/ctrl_writeReg/data_writeReg : write port
//   ctrl_issueEnable/ctrl_issueReg               : mark register pending
//   ctrl_readRegA/B -> data_readRegA/B, busy_readRegA/B : combinational read ports
//   busy_vector, busy_count                      : registered scoreboard state
//   write_onehot                                 : registered decode of the last write
// Optional: define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_scoreboard #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  localparam int NUM_REGS = 2**ADDR_W
) (
  input  logic                clock,
  input  logic                ctrl_reset,
  input  logic                ctrl_writeEnable,
  input  logic [ADDR_W-1:0]   ctrl_writeReg,
  input  logic [DATA_W-1:0]   data_writeReg,
  input  logic                ctrl_issueEnable,
  input  logic [ADDR_W-1:0]   ctrl_issueReg,
  input  logic [ADDR_W-1:0]   ctrl_readRegA,
  input  logic [ADDR_W-1:0]   ctrl_readRegB,
  output logic [DATA_W-1:0]   data_readRegA,
  output logic [DATA_W-1:0]   data_readRegB,
  output logic                busy_readRegA,
  output logic                busy_readRegB,
  output logic [NUM_REGS-1:0] busy_vector,
  output logic [ADDR_W:0]     busy_count,
  output logic [NUM_REGS-1:0] write_onehot
);
  logic [DATA_W-1:0]   mem [NUM_REGS];
  logic [NUM_REGS-1:0] write_dec, issue_dec, busy_next;
  logic [DATA_W-1:0]   stored_a, stored_b;
  logic                inc, dec;
  always_comb begin
    write_dec = {{(NUM_REGS-1){1'b0}}, ctrl_writeEnable} << ctrl_writeReg;
    issue_dec = {{(NUM_REGS-1){1'b0}}, ctrl_issueEnable} << ctrl_issueReg;
    // issue beats write on the same register; bit 0 never becomes busy
    busy_next = (issue_dec | (busy_vector & ~write_dec)) & ~{{(NUM_REGS-1){1'b0}}, 1'b1};
    inc = ctrl_issueEnable && ctrl_issueReg != '0 && !busy_vector[ctrl_issueReg];
    dec = ctrl_writeEnable && ctrl_writeReg != '0 && busy_vector[ctrl_writeReg] &&
          !(ctrl_issueEnable && ctrl_issueReg == ctrl_writeReg);
    stored_a = ctrl_readRegA == '0 ? '0 : mem[ctrl_readRegA];
    stored_b = ctrl_readRegB == '0 ? '0 : mem[ctrl_readRegB];
  end
`ifdef REGFILE_BYPASS_EN
  logic hit_a, hit_b;
  always_comb begin
    hit_a = ctrl_writeEnable && ctrl_writeReg != '0 && ctrl_writeReg == ctrl_readRegA;
    hit_b = ctrl_writeEnable && ctrl_writeReg != '0 && ctrl_writeReg == ctrl_readRegB;
    data_readRegA = hit_a ? data_writeReg : stored_a;
    data_readRegB = hit_b ? data_writeReg : stored_b;
    busy_readRegA = hit_a ? ctrl_issueEnable && ctrl_issueReg == ctrl_readRegA : busy_vector[ctrl_readRegA];
    busy_readRegB = hit_b ? ctrl_issueEnable && ctrl_issueReg == ctrl_readRegB : busy_vector[ctrl_readRegB];
  end
`else
  always_comb begin
    data_readRegA = stored_a;
    data_readRegB = stored_b;
    busy_readRegA = busy_vector[ctrl_readRegA];
    busy_readRegB = busy_vector[ctrl_readRegB];
  end
`endif
  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
      busy_vector  <= '0;
      busy_count   <= '0;
      write_onehot <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) if (write_dec[i]) mem[i] <= data_writeReg;
      busy_vector  <= busy_next;
      busy_count   <= busy_count + {{ADDR_W{1'b0}}, inc} - {{ADDR_W{1'b0}}, dec};
      write_onehot <= write_dec;
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed self-checking bench for regfile_scoreboard
module tb_regfile_scoreboard;
  logic        clock = 0;
  logic        ctrl_reset, ctrl_writeEnable, ctrl_issueEnable;
  logic [4:0]  ctrl_writeReg, ctrl_issueReg, ctrl_readRegA, ctrl_readRegB;
  logic [31:0] data_writeReg, data_readRegA, data_readRegB;
  logic        busy_readRegA, busy_readRegB;
  logic [31:0] busy_vector, write_onehot;
  logic [5:0]  busy_count;
  int checks = 0, errors = 0;

  regfile_scoreboard dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
    .ctrl_issueEnable(ctrl_issueEnable), .ctrl_issueReg(ctrl_issueReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
    .busy_readRegA(busy_readRegA), .busy_readRegB(busy_readRegB),
    .busy_vector(busy_vector), .busy_count(busy_count), .write_onehot(write_onehot)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle;
    ctrl_writeEnable = 0;
    ctrl_issueEnable = 0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    ctrl_writeEnable = 1;
    ctrl_writeReg = a;
    data_writeReg = d;
  endtask

  task automatic iss(input logic [4:0] a);
    ctrl_issueEnable = 1;
    ctrl_issueReg = a;
  endtask

  initial begin
    ctrl_reset = 0;
    ctrl_writeEnable = 0; ctrl_writeReg = 0; data_writeReg = 0;
    ctrl_issueEnable = 0; ctrl_issueReg = 0;
    ctrl_readRegA = 5; ctrl_readRegB = 0;
    tick; tick;
    ctrl_reset = 1;
    #1;
    chk("rst_busy", busy_vector, 0);
    chk("rst_count", busy_count, 0);
    chk("rst_onehot", write_onehot, 0);
    chk("rst_r5", data_readRegA, 0);

    wr(5, 32'hDEADBEEF); tick; idle; #1;
    chk("r5_read", data_readRegA, 32'hDEADBEEF);
    chk("onehot_r5", write_onehot, 32'h20);
    tick;
    chk("onehot_clr", write_onehot, 0);

    wr(0, 32'hFFFFFFFF); tick; idle;
    ctrl_readRegA = 0; ctrl_readRegB = 0; #1;
    chk("r0_a", data_readRegA, 0);
    chk("r0_b", data_readRegB, 0);
    chk("r0_busy0", busy_vector[0], 0);
    chk("onehot_r0", write_onehot, 32'h1);
    tick;
    chk("onehot_r0_clr", write_onehot, 0);

    iss(3); tick; iss(7); tick; idle;
    ctrl_readRegA = 3; #1;
    chk("busy_37", busy_vector, 32'h88);
    chk("count_37", busy_count, 2);
    chk("busy_rd_a3", busy_readRegA, 1);
    wr(3, 32'h11); tick; idle; #1;
    chk("busy_after_w3", busy_vector, 32'h80);
    chk("count_after_w3", busy_count, 1);
    chk("r3_read", data_readRegA, 32'h11);
    chk("busy_rd_a3_clr", busy_readRegA, 0);

    iss(9); wr(9, 32'h42); tick; idle;
    ctrl_readRegB = 9; #1;
    chk("busy_9", busy_vector, 32'h280);
    chk("count_9", busy_count, 2);
    chk("r9_read", data_readRegB, 32'h42);
    chk("busy_rd_b9", busy_readRegB, 1);

    iss(4); wr(7, 32'h77); tick; idle; #1;
    chk("busy_4_7", busy_vector, 32'h210);
    chk("count_4_7", busy_count, 2);

    iss(4); tick; idle; #1;
    chk("reissue_busy", busy_vector, 32'h210);
    chk("reissue_count", busy_count, 2);

    iss(0); wr(0, 32'h5); tick; idle; #1;
    chk("issue_r0_busy", busy_vector, 32'h210);
    chk("issue_r0_count", busy_count, 2);

    wr(5, 32'h99); tick; idle; #1;
    chk("write_nonbusy_busy", busy_vector, 32'h210);
    chk("write_nonbusy_count", busy_count, 2);

    wr(12, 32'h1234); tick; iss(12); tick; idle;
    ctrl_readRegA = 12; #1;
    chk("busy_12", busy_vector, 32'h1210);
    chk("count_12", busy_count, 3);
    wr(12, 32'hCAFE); #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_data", data_readRegA, 32'hCAFE);
    chk("byp_busy", busy_readRegA, 0);
`else
    chk("nobyp_data", data_readRegA, 32'h1234);
    chk("nobyp_busy", busy_readRegA, 1);
`endif
    iss(12); #1;
    chk("byp_issue_busy", busy_readRegA, 1);
    tick; idle; #1;
    chk("r12_read", data_readRegA, 32'hCAFE);
    chk("busy_12_kept", busy_vector, 32'h1210);
    chk("count_12_kept", busy_count, 3);

    wr(9, 32'h43); tick; idle; #1;
    chk("busy_w9", busy_vector, 32'h1010);
    chk("count_w9", busy_count, 2);

    ctrl_reset = 0; wr(5, 32'h55); iss(6); tick;
    ctrl_reset = 1; idle;
    ctrl_readRegA = 5; ctrl_readRegB = 12; #1;
    chk("mrst_busy", busy_vector, 0);
    chk("mrst_count", busy_count, 0);
    chk("mrst_onehot", write_onehot, 0);
    chk("mrst_r5", data_readRegA, 0);
    chk("mrst_r12", data_readRegB, 0);
    ctrl_readRegA = 3; ctrl_readRegB = 9; #1;
    chk("mrst_r3", data_readRegA, 0);
    chk("mrst_r9", data_readRegB, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
